// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared widths and requester-ID encoding for the dmem
//                arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int KBD_W      = 8;

  // Which requester owns the dmem port in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_KBD  = 2'd1,
    SEL_CPU  = 2'd2,
    SEL_VID  = 2'd3
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/dmem_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_prio_sel
//  Description : Fixed-priority grant selection with a video starvation
//                counter that forces a video grant after STARVE_MAX
//                consecutive denied video cycles. STARVE_MAX must be >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_prio_sel
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    kbd_pend,
  input  logic    cpu_req,
  input  logic    vid_req,
  output req_id_e sel
);

  localparam int               CNT_W        = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             w_force;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    w_force = vid_req && (starve_cnt_q >= C_STARVE_MAX);
    sel     = SEL_NONE;
    if (reset)         sel = SEL_NONE;
    else if (w_force)  sel = SEL_VID;
    else if (kbd_pend) sel = SEL_KBD;
    else if (cpu_req)  sel = SEL_CPU;
    else if (vid_req)  sel = SEL_VID;
  end

  // Count denied video cycles, saturating; any video grant or idle clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!vid_req || (sel == SEL_VID)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < C_STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port dmem arbiter for processor, VGA reader and a
//                PS/2 scancode mailbox writer. Owns the one-entry keyboard
//                holding register and the one-cycle read-return pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  input  logic              kbd_stb,
  input  logic [ADDR_W-1:0] kbd_addr,
  input  logic [KBD_W-1:0]  kbd_data,
  output logic              kbd_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] rdata
);

  req_id_e            w_sel;
  logic               w_kbd_gnt;
  logic               w_cpu_rd;
  logic               kbd_pend_q, kbd_pend_d;
  logic [KBD_W-1:0]   kbd_buf_q,  kbd_buf_d;
  logic               kbd_ovf_q,  kbd_ovf_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               vid_rvalid_q, vid_rvalid_d;
  logic [DATA_W-1:0]  rdata_q,    rdata_d;

  dmem_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clock    (clock),
    .reset    (reset),
    .kbd_pend (kbd_pend_q),
    .cpu_req  (cpu_req),
    .vid_req  (vid_req),
    .sel      (w_sel)
  );

  assign w_kbd_gnt = (w_sel == SEL_KBD);
  assign cpu_gnt   = (w_sel == SEL_CPU);
  assign vid_gnt   = (w_sel == SEL_VID);
  assign w_cpu_rd  = cpu_gnt && !cpu_we;

  // Route the granted requester onto the dmem port; idle drives all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    unique case (w_sel)
      SEL_KBD: begin
        mem_addr  = kbd_addr;
        mem_wdata = DATA_W'(kbd_buf_q);
        mem_wren  = 1'b1;
      end
      SEL_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_we;
      end
      SEL_VID: begin
        mem_addr  = vid_addr;
      end
      default: begin
      end
    endcase
  end

  // Keyboard holding register: a strobe refills the slot if it is empty or
  // being drained this cycle, otherwise the scancode is lost and flagged.
  always_comb begin
    kbd_pend_d = kbd_pend_q;
    kbd_buf_d  = kbd_buf_q;
    kbd_ovf_d  = kbd_ovf_q;
    if (w_kbd_gnt) kbd_pend_d = 1'b0;
    if (kbd_stb) begin
      if (!kbd_pend_q || w_kbd_gnt) begin
        kbd_pend_d = 1'b1;
        kbd_buf_d  = kbd_data;
      end else begin
        kbd_ovf_d  = 1'b1;
      end
    end
  end

  // Read return: a read granted now is flagged next cycle with its data.
  always_comb begin
    cpu_rvalid_d = w_cpu_rd;
    vid_rvalid_d = vid_gnt;
    rdata_d      = (w_cpu_rd || vid_gnt) ? mem_q : rdata_q;
  end

  // State registers for the holding slot and the read-return pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_pend_q   <= 1'b0;
      kbd_buf_q    <= '0;
      kbd_ovf_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      kbd_pend_q   <= kbd_pend_d;
      kbd_buf_q    <= kbd_buf_d;
      kbd_ovf_q    <= kbd_ovf_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // Masking with reset makes a read in flight vanish in the reset cycle
  // itself instead of one cycle later.
  assign cpu_rvalid = cpu_rvalid_q && !reset;
  assign vid_rvalid = vid_rvalid_q && !reset;
  assign kbd_ovf    = kbd_ovf_q && !reset;
  assign rdata      = reset ? '0 : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a read
//                return scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt, vid_rvalid;
  logic              kbd_stb = 1'b0;
  logic [ADDR_W-1:0] kbd_addr = 12'hFFF;
  logic [7:0]        kbd_data = '0;
  logic              kbd_ovf;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q = '0;
  logic [DATA_W-1:0] rdata;

  dmem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock (clock), .reset (reset),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
    .cpu_wdata (cpu_wdata), .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid),
    .vid_req (vid_req), .vid_addr (vid_addr), .vid_gnt (vid_gnt),
    .vid_rvalid (vid_rvalid),
    .kbd_stb (kbd_stb), .kbd_addr (kbd_addr), .kbd_data (kbd_data),
    .kbd_ovf (kbd_ovf),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wren (mem_wren),
    .mem_q (mem_q), .rdata (rdata)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          vid;
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit vid, input logic [31:0] d);
    sb.push_back('{vid: vid, data: d, due: cyc + 1});
  endtask

  task automatic cyc_start();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_vid_gnt"}, vid_gnt, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wren"}, mem_wren, 0);
  endtask

  // Read-return monitor: every cycle either the due read returns or no rvalid.
  always @(negedge clock) begin
    rd_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rv_cpu", cpu_rvalid, e.vid ? 64'd0 : 64'd1);
      chk("rv_vid", vid_rvalid, e.vid ? 64'd1 : 64'd0);
      chk("rv_data", rdata, e.data);
    end else begin
      chk("rv_idle", {cpu_rvalid, vid_rvalid}, 0);
    end
  end

  initial begin
    // Reset state
    cyc_start(); sample();
    chk_idle("rst");
    chk("rst_rdata", rdata, 0);
    chk("rst_ovf", kbd_ovf, 0);
    cyc_start(); reset = 1'b0; sample();
    chk_idle("post_rst");

    // CPU read
    cyc_start(); cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010; mem_q = 32'hDEADBEEF;
    sample();
    chk("rd_gnt", cpu_gnt, 1);
    chk("rd_addr", mem_addr, 12'h010);
    chk("rd_wren", mem_wren, 0);
    push(0, 32'hDEADBEEF);
    cyc_start(); cpu_req = 0; sample();
    chk_idle("rd_after");

    // CPU write (never returns rvalid)
    cyc_start(); cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 32'hCAFEF00D;
    sample();
    chk("wr_gnt", cpu_gnt, 1);
    chk("wr_wren", mem_wren, 1);
    chk("wr_addr", mem_addr, 12'h123);
    chk("wr_wdata", mem_wdata, 32'hCAFEF00D);
    cyc_start(); cpu_req = 0; cpu_we = 0; sample();
    chk_idle("wr_after");

    // Starvation: CPU wins 8 cycles, then video is forced
    cyc_start(); cpu_req = 1; cpu_addr = 12'h020; vid_req = 1; vid_addr = 12'h300;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc_start();
      mem_q = 32'h1111_0000 + i;
      sample();
      chk("starve_cpu_gnt", cpu_gnt, 1);
      chk("starve_vid_gnt", vid_gnt, 0);
      push(0, mem_q);
    end
    cyc_start(); mem_q = 32'hBEEF_0300; sample();
    chk("force_vid_gnt", vid_gnt, 1);
    chk("force_cpu_gnt", cpu_gnt, 0);
    chk("force_addr", mem_addr, 12'h300);
    chk("force_wren", mem_wren, 0);
    push(1, mem_q);
    cyc_start(); mem_q = 32'h2222_0000; sample();
    chk("after_force_cpu", cpu_gnt, 1);
    push(0, mem_q);
    cyc_start(); cpu_req = 0; vid_req = 0; sample();
    chk_idle("starve_done");

    // Keyboard write preempts a waiting CPU for one cycle
    cyc_start(); cpu_req = 1; cpu_addr = 12'h040; mem_q = 32'h0000_4040;
    kbd_stb = 1; kbd_data = 8'h1C; kbd_addr = 12'hFFF;
    sample();
    chk("kbd_cyc0_cpu", cpu_gnt, 1);
    push(0, mem_q);
    cyc_start(); kbd_stb = 0; sample();
    chk("kbd_cpu_gnt", cpu_gnt, 0);
    chk("kbd_vid_gnt", vid_gnt, 0);
    chk("kbd_wren", mem_wren, 1);
    chk("kbd_addr", mem_addr, 12'hFFF);
    chk("kbd_wdata", mem_wdata, 32'h0000001C);
    cyc_start(); mem_q = 32'h0000_4141; sample();
    chk("kbd_then_cpu", cpu_gnt, 1);
    chk("kbd_no_ovf", kbd_ovf, 0);
    push(0, mem_q);
    cyc_start(); cpu_req = 0; sample();
    chk_idle("kbd_done");

    // Strobe arriving while the pending entry is granted is captured
    cyc_start(); kbd_stb = 1; kbd_data = 8'hA1; sample();
    chk("cap_idle_wren", mem_wren, 0);
    cyc_start(); kbd_stb = 1; kbd_data = 8'h2A; sample();
    chk("cap_first_wren", mem_wren, 1);
    chk("cap_first_data", mem_wdata, 32'h000000A1);
    cyc_start(); kbd_stb = 0; sample();
    chk("cap_second_wren", mem_wren, 1);
    chk("cap_second_data", mem_wdata, 32'h0000002A);
    chk("cap_no_ovf", kbd_ovf, 0);
    cyc_start(); sample();
    chk("cap_drained", mem_wren, 0);

    // Overflow: second strobe lands while forced video holds the port
    cyc_start(); cpu_req = 1; cpu_addr = 12'h050; vid_req = 1; vid_addr = 12'h310;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc_start();
      mem_q = 32'h3333_0000 + i;
      kbd_stb = (i == 7);
      kbd_data = 8'h55;
      sample();
      chk("ovf_build_cpu", cpu_gnt, 1);
      push(0, mem_q);
    end
    cyc_start(); kbd_stb = 1; kbd_data = 8'h66; mem_q = 32'hBEEF_0310; sample();
    chk("ovf_force_vid", vid_gnt, 1);
    push(1, mem_q);
    cyc_start(); kbd_stb = 0; sample();
    chk("ovf_kbd_wren", mem_wren, 1);
    chk("ovf_kbd_data", mem_wdata, 32'h00000055);
    chk("ovf_flag", kbd_ovf, 1);
    cyc_start(); mem_q = 32'h4444_0000; sample();
    chk("ovf_no_second", cpu_gnt, 1);
    push(0, mem_q);
    cyc_start(); cpu_req = 0; vid_req = 0; sample();
    chk("ovf_sticky", kbd_ovf, 1);
    chk_idle("ovf_done");

    // Reset right after a video read grant drops the return
    cyc_start(); vid_req = 1; vid_addr = 12'h3AA; mem_q = 32'h5A5A5A5A; sample();
    chk("rst_vid_gnt", vid_gnt, 1);
    cyc_start(); vid_req = 0; reset = 1; sample();
    chk("rst_vid_rvalid", vid_rvalid, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_rdata2", rdata, 0);
    chk("rst_ovf2", kbd_ovf, 0);
    chk_idle("rst2");
    cyc_start(); reset = 0; cpu_req = 1; cpu_addr = 12'h0AB; mem_q = 32'h0000_0077; sample();
    chk("rst_cpu_first", cpu_gnt, 1);
    chk("rst_ovf_clr", kbd_ovf, 0);
    push(0, mem_q);
    cyc_start(); cpu_req = 0; sample();
    cyc_start(); sample();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
